// File: rtl/detect_scan_ctrl.sv
// detect_scan_ctrl
//   Shares one 8-bit sequence-detector datapath among N requesters.
//   A round-robin arbiter picks a pending request and latches its word. The
//   word is loaded into the detector with a one-cycle det_set strobe. The
//   detector's det_detect output is then watched for SCAN_LEN cycles, and the
//   hit result is returned to the winner with a one-cycle done pulse. A
//   saturating count of hitting jobs is also kept.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   req[N]          request levels, held until grant
//   req_data[N*DW]  requester i word in bits [i*DW +: DW]
//   grant[N]        one-hot pulse: request accepted, word latched
//   done[N]         one-hot pulse: job finished, hit valid
//   hit             job result, only meaningful while done != 0
//   det_set         detector load strobe
//   det_data[DW]    word driven to the detector
//   det_detect      detector match output
//   busy            controller not idle
//   hit_count[CW]   saturating count of jobs with hit=1
module detect_scan_ctrl #(
    parameter int N        = 2,
    parameter int DW       = 8,
    parameter int SCAN_LEN = 10,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] req_data,
    output logic [N-1:0]    grant,
    output logic [N-1:0]    done,
    output logic            hit,
    output logic            det_set,
    output logic [DW-1:0]   det_data,
    input  logic            det_detect,
    output logic            busy,
    output logic [CW-1:0]   hit_count
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_REPORT} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_n;
    logic [IW-1:0] cur, cur_n;
    logic [SW-1:0] scan_cnt, cnt_n;
    logic          hit_flag, flag_n;
    logic [DW-1:0] data_n;
    logic [N-1:0]  grant_n, done_n;
    logic          hit_n, set_n;
    logic [CW-1:0] hc_n;

    logic          win_vld;
    logic [IW-1:0] win_idx;

    // Round-robin pick: walk from rr_ptr downward in priority order. The
    // loop runs from the lowest priority to the highest, so the last match
    // written is the highest-priority requester.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = IW'(idx);
            end
        end
    end

    // Next-state and next-output logic. Every output is registered from
    // these values, so nothing combinational reaches a port.
    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        cur_n   = cur;
        cnt_n   = scan_cnt;
        flag_n  = hit_flag;
        data_n  = det_data;
        grant_n = '0;
        done_n  = '0;
        hit_n   = 1'b0;
        set_n   = 1'b0;
        hc_n    = hit_count;
        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    state_n          = S_LOAD;
                    cur_n            = win_idx;
                    data_n           = req_data[int'(win_idx)*DW +: DW];
                    grant_n[win_idx] = 1'b1;
                    set_n            = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_SCAN;
                cnt_n   = '0;
                flag_n  = 1'b0;
            end
            S_SCAN: begin
                flag_n = hit_flag | det_detect;
                if (scan_cnt == SW'(SCAN_LEN - 1)) begin
                    // done/hit register on this edge so they are visible
                    // during the REPORT cycle, including the final sample.
                    state_n     = S_REPORT;
                    done_n[cur] = 1'b1;
                    hit_n       = flag_n;
                    if (flag_n && (hit_count != {CW{1'b1}}))
                        hc_n = hit_count + 1'b1;
                    if (int'(cur) == N - 1) rr_n = '0;
                    else                    rr_n = cur + 1'b1;
                end else begin
                    cnt_n = scan_cnt + 1'b1;
                end
            end
            S_REPORT: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            cur       <= '0;
            scan_cnt  <= '0;
            hit_flag  <= 1'b0;
            grant     <= '0;
            done      <= '0;
            hit       <= 1'b0;
            det_set   <= 1'b0;
            det_data  <= '0;
            busy      <= 1'b0;
            hit_count <= '0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            cur       <= cur_n;
            scan_cnt  <= cnt_n;
            hit_flag  <= flag_n;
            grant     <= grant_n;
            done      <= done_n;
            hit       <= hit_n;
            det_set   <= set_n;
            det_data  <= data_n;
            busy      <= (state_n != S_IDLE);
            hit_count <= hc_n;
        end
    end

endmodule

// File: doc/detect_scan_ctrl.md
Name: detect_scan_ctrl

Overview:
- Sequences the shared 8-bit sequence-detector datapath (set / data / detect interface) among N requesters.
- Round-robin arbitration over pending requests. The granted word is latched and loaded into the detector with a one-cycle set pulse.
- The detector's detect output is observed for a fixed scan window, and a per-job hit result is returned to the winning requester. A saturating total-hit counter is also kept.

Parameters:
- N, 2, number of requesters (2..4)
- DW, 8, data word width presented to the detector
- SCAN_LEN, 10, detector observation window in clock cycles (≥1)
- CW, 8, width of hit_count

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req  in  N  per-requester request level; held until grant
- req_data  in  N*DW  requester i word in bits [i*DW +: DW]
- grant  out  N  one-hot, one-cycle pulse: request i accepted, data latched
- done  out  N  one-hot, one-cycle pulse: job i finished, hit valid
- hit  out  1  result of the finished job, valid only while any done bit is high
- det_set  out  1  one-cycle load strobe to the detector
- det_data  out  DW  word driven to the detector, stable from LOAD through REPORT
- det_detect  in  1  detector match output
- busy  out  1  high in any state other than IDLE
- hit_count  out  CW  total jobs with hit=1, saturating

Behaviour:
- Reset (rst=1 at a clock edge, takes priority in any state):
  - state=IDLE; rr_ptr=0; all outputs 0, including det_data and hit_count.
  - An in-flight job is discarded: no done pulse is produced for it.
- All outputs are registered. No combinational path from req to grant.
- State IDLE:
  - If req≠0, select the first set bit searching i = rr_ptr, rr_ptr+1, ... mod N.
  - Latch req_data of the winner into det_data and store its index in cur.
  - Pulse grant[cur] in the next cycle, together with the move to LOAD.
  - If req=0, remain in IDLE.
- State LOAD (1 cycle):
  - det_set=1; hit_flag cleared.
  - Next state is SCAN with scan_cnt=0.
- State SCAN (exactly SCAN_LEN cycles):
  - Each cycle: hit_flag |= det_detect.
  - Advance to REPORT when scan_cnt == SCAN_LEN-1.
  - det_detect is ignored in every other state.
- State REPORT (1 cycle):
  - done[cur]=1; hit = final hit_flag, including the detect value sampled in the last SCAN cycle.
  - If hit, hit_count increments; it holds at 2^CW-1.
  - rr_ptr = (cur+1) mod N; next state IDLE.
- Latency: req first seen high in IDLE at edge t gives:
  - grant and det_set high during cycle t+1
  - SCAN during cycles t+2 .. t+1+SCAN_LEN
  - done at t+2+SCAN_LEN
  - busy=0 at t+3+SCAN_LEN; the earliest next grant is at t+4+SCAN_LEN.
- Requests:
  - Requests arriving while busy are not sampled until IDLE.
  - A requester dropping req before its grant is simply not selected; nothing is latched.
  - The granted requester must drop req in the cycle after grant. If it re-asserts, it competes again at the lowest priority.
- Simultaneous requests: rr_ptr gives fairness. With all requests held high, grants rotate 0,1,...,N-1,0.
- Reset low-to-high mid-SCAN: det_set stays 0, busy falls in the cycle after the reset edge, and no spurious done is produced.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then req=0 for 20 cycles -> all outputs 0, busy=0, det_set never pulses.
2. Single job, hit:
   - Stimulus: req[0]=1, req_data[7:0]=8'h57; the detector model raises det_detect for 1 cycle in SCAN cycle 4.
   - Required: grant[0] and det_set pulse together with det_data=8'h57; done[0] exactly 1+SCAN_LEN cycles after grant (11); hit=1; hit_count=1.
3. Single job, no hit:
   - Stimulus: req[1]=1, data 8'h15; det_detect held at 0.
   - Required: done[1]=1, hit=0, hit_count unchanged.
4. Boundary sampling: det_detect pulses only in the LOAD cycle and in the cycle after REPORT -> hit=0. A pulse only in the last SCAN cycle -> hit=1.
5. Arbitration:
   - Stimulus: req=2'b11 held, with each requester dropping for 1 cycle after its grant.
   - Required: grant order 0,1,0,1; det_data switches to the granted word; the gap between consecutive grants is SCAN_LEN+3 = 13 cycles.
6. Reset mid-scan and saturation:
   - Reset: rst=1 in SCAN cycle 5 -> no done, busy=0 next cycle, hit_count=0.
   - Saturation (separate run, CW=2 override): 5 hitting jobs -> hit_count sequence 1,2,3,3,3.
